// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state encodings, instruction field constants and control encodings
// shared by the multicycle sequencer and its ALU function decoder.
package alu_seq_pkg;

   typedef logic [2:0] alu_sel_t;

   // FSM state encoding, also exported on state_o for debug
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_FETCH     = 4'd1;
   localparam logic [3:0] ST_DECODE    = 4'd2;
   localparam logic [3:0] ST_R_EXEC    = 4'd3;
   localparam logic [3:0] ST_R_WB      = 4'd4;
   localparam logic [3:0] ST_MEM_ADDR  = 4'd5;
   localparam logic [3:0] ST_MEM_READ  = 4'd6;
   localparam logic [3:0] ST_MEM_WB    = 4'd7;
   localparam logic [3:0] ST_MEM_WRITE = 4'd8;
   localparam logic [3:0] ST_I_EXEC    = 4'd9;
   localparam logic [3:0] ST_I_WB      = 4'd10;
   localparam logic [3:0] ST_BRANCH    = 4'd11;
   localparam logic [3:0] ST_ILLEGAL   = 4'd12;
   // JUMP sits above ILLEGAL so the illegal trap keeps its fixed debug code 12
   localparam logic [3:0] ST_JUMP      = 4'd13;

   // Opcodes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   // ALU select codes
   localparam alu_sel_t ALU_PASS_B = 3'b000;
   localparam alu_sel_t ALU_SLT    = 3'b001;
   localparam alu_sel_t ALU_ADD    = 3'b010;
   localparam alu_sel_t ALU_SUB    = 3'b011;
   localparam alu_sel_t ALU_PASS_A = 3'b100;
   localparam alu_sel_t ALU_EQ     = 3'b110;
   localparam alu_sel_t ALU_AND    = 3'b111;

   // ALU operand B mux
   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   // PC source mux
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // Immediate-ALU opcodes that go through I_EXEC
   function automatic logic is_i_type(input logic [5:0] opc);
      return (opc == OPC_ADDI) || (opc == OPC_ANDI) || (opc == OPC_SLTI) || (opc == OPC_LUI);
   endfunction

endpackage

// File: rtl/alu_sequencer_alu_func_decode.sv
// alu_func_decode: combinational map of (state, opcode, funct) to the ALU select code.
// o_valid drops for an undefined funct in R_EXEC (or undefined opcode in I_EXEC).
module alu_func_decode
   import alu_seq_pkg::*;
#(
   parameter int unsigned OPC_W   = 6,
   parameter int unsigned FUNCT_W = 6
) (
   input  logic [3:0]         i_state,
   input  logic [OPC_W-1:0]   i_opcode,
   input  logic [FUNCT_W-1:0] i_funct,
   output alu_sel_t           o_alu_select,
   output logic               o_valid
);

   // Select code per state; R/I execute states decode their instruction field
   always_comb begin
      o_alu_select = ALU_PASS_B;
      o_valid      = 1'b1;
      case (i_state)
         ST_FETCH, ST_DECODE, ST_MEM_ADDR: o_alu_select = ALU_ADD;
         ST_BRANCH:                        o_alu_select = ALU_EQ;
         ST_R_EXEC: begin
            case (i_funct)
               FUNCT_ADD: o_alu_select = ALU_ADD;
               FUNCT_SUB: o_alu_select = ALU_SUB;
               FUNCT_AND: o_alu_select = ALU_AND;
               FUNCT_SLT: o_alu_select = ALU_SLT;
               default:   o_valid      = 1'b0;
            endcase
         end
         ST_I_EXEC: begin
            case (i_opcode)
               OPC_ADDI: o_alu_select = ALU_ADD;
               OPC_ANDI: o_alu_select = ALU_AND;
               OPC_SLTI: o_alu_select = ALU_SLT;
               OPC_LUI:  o_alu_select = ALU_PASS_B;
               default:  o_valid      = 1'b0;
            endcase
         end
         default: o_alu_select = ALU_PASS_B;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multicycle control FSM (fetch/decode/execute/memory/writeback) for the
// 32-bit datapath. Moore outputs from the state register; pc_en folds in alu_zero.
// Optional feature macro ALU_SEQ_MEM_WAIT_EN: FETCH, MEM_READ and MEM_WRITE stall while
// mem_ready is low. Without it mem_ready is ignored.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned OPC_W   = 6,
   parameter int unsigned FUNCT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [OPC_W-1:0]   opcode,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               alu_zero,
   input  logic               mem_ready,
   output logic [2:0]         alu_select,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               i_or_d,
   output logic               ir_write,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               pc_en,
   output logic [1:0]         pc_source,
   output logic               instr_done,
   output logic               illegal,
   output logic [3:0]         state_o
);

   logic [3:0]       r_state;
   logic [3:0]       w_state_next;
   logic [OPC_W-1:0] r_opcode;
   alu_sel_t         w_dec_sel;
   logic             w_dec_valid;
   logic             w_mem_ok;

`ifdef ALU_SEQ_MEM_WAIT_EN
   assign w_mem_ok = mem_ready;
`else
   logic w_unused_mem_ready;
   assign w_unused_mem_ready = mem_ready;
   assign w_mem_ok           = 1'b1;
`endif

   // Opcode is latched in DECODE so later states ignore IR changes
   alu_func_decode #(
      .OPC_W   (OPC_W),
      .FUNCT_W (FUNCT_W)
   ) u_func_decode (
      .i_state      (r_state),
      .i_opcode     (r_opcode),
      .i_funct      (funct),
      .o_alu_select (w_dec_sel),
      .o_valid      (w_dec_valid)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Capture opcode in DECODE for the I_EXEC select and lw/sw split
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_opcode <= '0;
      else if (r_state == ST_DECODE)  r_opcode <= opcode;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  w_state_next = ST_FETCH;
         ST_FETCH: if (w_mem_ok) w_state_next = ST_DECODE;
         ST_DECODE: begin
            if (opcode == OPC_RTYPE)                          w_state_next = ST_R_EXEC;
            else if ((opcode == OPC_LW) || (opcode == OPC_SW)) w_state_next = ST_MEM_ADDR;
            else if (opcode == OPC_BEQ)                       w_state_next = ST_BRANCH;
            else if (opcode == OPC_J)                         w_state_next = ST_JUMP;
            else if (is_i_type(opcode))                       w_state_next = ST_I_EXEC;
            else                                              w_state_next = ST_ILLEGAL;
         end
         ST_R_EXEC:    w_state_next = w_dec_valid ? ST_R_WB : ST_ILLEGAL;
         ST_R_WB:      w_state_next = ST_FETCH;
         ST_MEM_ADDR:  w_state_next = (r_opcode == OPC_LW) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ:  if (w_mem_ok) w_state_next = ST_MEM_WB;
         ST_MEM_WB:    w_state_next = ST_FETCH;
         ST_MEM_WRITE: if (w_mem_ok) w_state_next = ST_FETCH;
         ST_I_EXEC:    w_state_next = ST_I_WB;
         ST_I_WB:      w_state_next = ST_FETCH;
         ST_BRANCH:    w_state_next = ST_FETCH;
         ST_JUMP:      w_state_next = ST_FETCH;
         ST_ILLEGAL:   w_state_next = ST_ILLEGAL;
         default:      w_state_next = ST_ILLEGAL;
      endcase
   end

   // Control outputs decoded from state (mem_ready gating only with the wait feature)
   always_comb begin
      alu_src_a     = 1'b0;
      alu_src_b     = SRC_B_REG;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PC_SRC_ALU;
      instr_done    = 1'b0;
      illegal       = 1'b0;
      case (r_state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = w_mem_ok;
            pc_write  = w_mem_ok;
            alu_src_b = SRC_B_FOUR;
         end
         ST_DECODE:   alu_src_b = SRC_B_IMM_SH;
         ST_R_EXEC:   alu_src_a = 1'b1;
         ST_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         ST_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         ST_MEM_READ: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
         end
         ST_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         ST_MEM_WRITE: begin
            i_or_d     = 1'b1;
            mem_write  = 1'b1;
            instr_done = w_mem_ok;
         end
         ST_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         ST_I_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a     = 1'b1;
            pc_write_cond = 1'b1;
            pc_source     = PC_SRC_ALUOUT;
            instr_done    = 1'b1;
         end
         ST_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PC_SRC_JUMP;
            instr_done = 1'b1;
         end
         ST_ILLEGAL:  illegal = 1'b1;
         default:     illegal = 1'b0;
      endcase
   end

   assign alu_select = w_dec_sel;
   assign pc_en      = pc_write | (pc_write_cond & alu_zero);
   assign state_o    = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: instruction-level model of the sequencer. Each instruction is expanded
// into its list of phases; a compare process checks every cycle against that list.
module tb_alu_sequencer;

   typedef struct packed {
      logic [2:0] sel;
      logic       sa;
      logic [1:0] sb;
      logic       iord, irw, mr, mw, rw, m2r, rd, pcw, pcwc, pcen;
      logic [1:0] pcs;
      logic       done, ill;
   } ctrl_t;

   localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_REXEC = 3, PH_RWB = 4;
   localparam int PH_MADDR = 5, PH_MREAD = 6, PH_MWB = 7, PH_MWRITE = 8, PH_MWAIT = 9;
   localparam int PH_IEXEC = 10, PH_IWB = 11, PH_BRANCH = 12, PH_JUMP = 13, PH_ILL = 14;

   logic       clk, rst_n, alu_zero, mem_ready;
   logic [5:0] opcode, funct;
   logic [2:0] alu_select;
   logic [1:0] alu_src_b, pc_source;
   logic       alu_src_a, i_or_d, ir_write, mem_read, mem_write, reg_write, mem_to_reg;
   logic       reg_dst, pc_write, pc_write_cond, pc_en, instr_done, illegal;
   logic [3:0] state_o;

   int total = 0;
   int bad   = 0;

   ctrl_t      exp_q[$];
   ctrl_t      msk_q[$];
   string      nm_q[$];
   logic [4:0] st_q[$];

   ctrl_t act;
   assign act = {alu_select, alu_src_a, alu_src_b, i_or_d, ir_write, mem_read, mem_write,
                 reg_write, mem_to_reg, reg_dst, pc_write, pc_write_cond, pc_en, pc_source,
                 instr_done, illegal};

   alu_sequencer #(
      .OPC_W   (6),
      .FUNCT_W (6)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .funct         (funct),
      .alu_zero      (alu_zero),
      .mem_ready     (mem_ready),
      .alu_select    (alu_select),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .i_or_d        (i_or_d),
      .ir_write      (ir_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_en         (pc_en),
      .pc_source     (pc_source),
      .instr_done    (instr_done),
      .illegal       (illegal),
      .state_o       (state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected outputs of one phase, straight from the phase descriptions
   function automatic ctrl_t ph(input int p, input logic [2:0] sel, input logic z);
      ctrl_t c;
      c = '0;
      case (p)
         PH_FETCH:  begin c.mr = 1; c.irw = 1; c.pcw = 1; c.pcen = 1; c.sb = 2'b01; c.sel = 3'b010; end
         PH_DECODE: begin c.sb = 2'b11; c.sel = 3'b010; end
         PH_REXEC:  begin c.sa = 1; c.sel = sel; end
         PH_RWB:    begin c.rw = 1; c.rd = 1; c.done = 1; end
         PH_MADDR:  begin c.sa = 1; c.sb = 2'b10; c.sel = 3'b010; end
         PH_MREAD:  begin c.iord = 1; c.mr = 1; end
         PH_MWB:    begin c.rw = 1; c.m2r = 1; c.done = 1; end
         PH_MWRITE: begin c.iord = 1; c.mw = 1; c.done = 1; end
         PH_MWAIT:  begin c.iord = 1; c.mw = 1; end
         PH_IEXEC:  begin c.sa = 1; c.sb = 2'b10; c.sel = sel; end
         PH_IWB:    begin c.rw = 1; c.done = 1; end
         PH_BRANCH: begin c.sa = 1; c.sel = 3'b110; c.pcwc = 1; c.pcs = 2'b01; c.done = 1; c.pcen = z; end
         PH_JUMP:   begin c.pcw = 1; c.pcen = 1; c.pcs = 2'b10; c.done = 1; end
         PH_ILL:    c.ill = 1;
         default:   c = '0;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] r_sel(input logic [5:0] fn);
      case (fn)
         6'h20:   return 3'b010;
         6'h22:   return 3'b011;
         6'h24:   return 3'b111;
         6'h2A:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] i_sel(input logic [5:0] opc);
      case (opc)
         6'h08:   return 3'b010;
         6'h0C:   return 3'b111;
         6'h0A:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic push(input int p, input logic [2:0] sel, input logic z, input string nm,
                       input logic chk, input logic [3:0] st, input logic sel_dc);
      ctrl_t m;
      m = '1;
      if (sel_dc) m.sel = 3'b000;
      exp_q.push_back(ph(p, sel, z));
      msk_q.push_back(m);
      nm_q.push_back(nm);
      st_q.push_back({chk, st});
   endtask

   task automatic lit(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   // Wait for the expectation list to drain; report latency and pc_en at instr_done
   task automatic drain(output int lat, output logic pe);
      lat = 0;
      pe  = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         #2;
         if (instr_done && lat == 0) begin
            lat = k;
            pe  = pc_en;
         end
         if (exp_q.size() == 0) return;
      end
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete(); msk_q.delete(); nm_q.delete(); st_q.delete();
   endtask

   task automatic run(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                      input string nm, input logic chg, output int lat, output logic pe);
      opcode   = opc;
      funct    = fn;
      alu_zero = z;
      push(PH_FETCH, 3'b0, z, {nm, "_fetch"}, 0, 4'd0, 0);
      push(PH_DECODE, 3'b0, z, {nm, "_decode"}, 0, 4'd0, 0);
      case (opc)
         6'h00: begin
            push(PH_REXEC, r_sel(fn), z, {nm, "_rexec"}, 0, 4'd0, 0);
            push(PH_RWB, 3'b0, z, {nm, "_rwb"}, 0, 4'd0, 0);
         end
         6'h23: begin
            push(PH_MADDR, 3'b0, z, {nm, "_maddr"}, 0, 4'd0, 0);
            push(PH_MREAD, 3'b0, z, {nm, "_mread"}, 0, 4'd0, 0);
            push(PH_MWB, 3'b0, z, {nm, "_mwb"}, 0, 4'd0, 0);
         end
         6'h2B: begin
            push(PH_MADDR, 3'b0, z, {nm, "_maddr"}, 0, 4'd0, 0);
            push(PH_MWRITE, 3'b0, z, {nm, "_mwrite"}, 0, 4'd0, 0);
         end
         6'h04: push(PH_BRANCH, 3'b0, z, {nm, "_branch"}, 0, 4'd0, 0);
         6'h02: push(PH_JUMP, 3'b0, z, {nm, "_jump"}, 0, 4'd0, 0);
         default: begin
            push(PH_IEXEC, i_sel(opc), z, {nm, "_iexec"}, 0, 4'd0, 0);
            push(PH_IWB, 3'b0, z, {nm, "_iwb"}, 0, 4'd0, 0);
         end
      endcase
      // Change the IR opcode once DECODE is over; the running instruction must not notice
      if (chg) fork
         begin
            repeat (3) @(posedge clk);
            #1 opcode = 6'h0C;
         end
      join_none
      drain(lat, pe);
   endtask

   task automatic do_reset(input string nm);
      int   lat;
      logic pe;
      push(PH_IDLE, 3'b0, 0, {nm, "_idle0"}, 1, 4'd0, 0);
      push(PH_IDLE, 3'b0, 0, {nm, "_idle1"}, 1, 4'd0, 0);
      rst_n = 1'b0;
      #1;
      lit({nm, "_async_state"}, int'(state_o), 0);
      drain(lat, pe);
      lit({nm, "_illegal_clr"}, int'(illegal), 0);
      rst_n = 1'b1;
   endtask

   task automatic run_illegal(input logic [5:0] opc, input logic [5:0] fn, input string nm);
      int   lat;
      logic pe;
      opcode = opc;
      funct  = fn;
      push(PH_FETCH, 3'b0, 0, {nm, "_fetch"}, 0, 4'd0, 0);
      push(PH_DECODE, 3'b0, 0, {nm, "_decode"}, 0, 4'd0, 0);
      if (opc == 6'h00) push(PH_REXEC, 3'b0, 0, {nm, "_rexec"}, 0, 4'd0, 1);
      for (int i = 0; i < 20; i++) push(PH_ILL, 3'b0, 0, {nm, "_trap"}, 1, 4'd12, 0);
      drain(lat, pe);
      lit({nm, "_no_done"}, lat, 0);
      lit({nm, "_sticky"}, int'(illegal), 1);
      do_reset({nm, "_rst"});
   endtask

   // Per-cycle compare against the expectation list
   initial begin
      ctrl_t      e, m;
      string      nm;
      logic [4:0] s;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            m  = msk_q.pop_front();
            nm = nm_q.pop_front();
            s  = st_q.pop_front();
            total++;
            if ((((act ^ e) & m) != '0) || (s[4] && (state_o != s[3:0]))) begin
               bad++;
               $display("FAIL %s: got ctrl=%b state=%0d want ctrl=%b state=%0d (mask %b)",
                        nm, act, state_o, e, s[3:0], m);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic pe;
      rst_n     = 1'b0;
      opcode    = '0;
      funct     = '0;
      alu_zero  = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) push(PH_IDLE, 3'b0, 0, "reset_idle", 1, 4'd0, 0);
      drain(lat, pe);
      lit("reset_state", int'(state_o), 0);
      rst_n = 1'b1;

      run(6'h23, 6'h00, 0, "lw", 0, lat, pe);     lit("lw_latency", lat, 5);
      run(6'h2B, 6'h00, 0, "sw", 0, lat, pe);     lit("sw_latency", lat, 4);
      run(6'h00, 6'h22, 0, "sub", 0, lat, pe);    lit("sub_latency", lat, 4);
      run(6'h00, 6'h20, 1, "add", 0, lat, pe);    lit("add_latency", lat, 4);
      run(6'h00, 6'h24, 0, "and", 0, lat, pe);    lit("and_latency", lat, 4);
      run(6'h00, 6'h2A, 0, "slt", 0, lat, pe);    lit("slt_latency", lat, 4);
      run(6'h08, 6'h00, 0, "addi_chg", 1, lat, pe); lit("addi_latency", lat, 4);
      run(6'h0C, 6'h00, 0, "andi", 0, lat, pe);   lit("andi_latency", lat, 4);
      run(6'h0A, 6'h00, 0, "slti", 0, lat, pe);   lit("slti_latency", lat, 4);
      run(6'h0F, 6'h00, 0, "lui", 0, lat, pe);    lit("lui_latency", lat, 4);
      run(6'h04, 6'h00, 1, "beq_t", 0, lat, pe);  lit("beq_t_latency", lat, 3);
      lit("beq_t_pc_en", int'(pe), 1);
      run(6'h04, 6'h00, 0, "beq_n", 0, lat, pe);  lit("beq_n_latency", lat, 3);
      lit("beq_n_pc_en", int'(pe), 0);
      run(6'h02, 6'h00, 0, "j", 0, lat, pe);      lit("j_latency", lat, 3);

      // Reset while lw is in MEM_ADDR: no memory read or writeback may follow
      opcode = 6'h23;
      push(PH_FETCH, 3'b0, 0, "lwcut_fetch", 0, 4'd0, 0);
      push(PH_DECODE, 3'b0, 0, "lwcut_decode", 0, 4'd0, 0);
      push(PH_MADDR, 3'b0, 0, "lwcut_maddr", 0, 4'd0, 0);
      drain(lat, pe);
      do_reset("lwcut_rst");

      run_illegal(6'h3F, 6'h00, "ill_opc");
      run_illegal(6'h00, 6'h07, "ill_funct");

`ifdef ALU_SEQ_MEM_WAIT_EN
      // sw with mem_ready low for the first three MEM_WRITE cycles
      opcode = 6'h2B;
      push(PH_FETCH, 3'b0, 0, "sww_fetch", 0, 4'd0, 0);
      push(PH_DECODE, 3'b0, 0, "sww_decode", 0, 4'd0, 0);
      push(PH_MADDR, 3'b0, 0, "sww_maddr", 0, 4'd0, 0);
      for (int i = 0; i < 3; i++) push(PH_MWAIT, 3'b0, 0, "sww_wait", 0, 4'd0, 0);
      push(PH_MWRITE, 3'b0, 0, "sww_mwrite", 0, 4'd0, 0);
      fork
         begin
            repeat (4) @(posedge clk);
            #1 mem_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 mem_ready = 1'b1;
         end
      join_none
      drain(lat, pe);
      lit("sww_latency", lat, 7);
`endif

      run(6'h00, 6'h22, 0, "sub_after", 0, lat, pe); lit("sub_after_latency", lat, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
